// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, freeze and flush.
// Optional 2-entry skid buffer fully registers the backpressure path.
module pipe_stage_reg #(
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0,
  parameter bit                    SKID_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  in_fire, out_fire;

  assign out_valid = main_valid_q & ~freeze;
  assign out_data  = main_data_q;
  assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Upstream ready: registered-only with skid, pass-through without.
  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = ~rst & ~skid_valid_q & ~freeze & ~flush;
    end else begin : g_noskid
      assign in_ready = ~rst & (~main_valid_q | out_ready)
                      & ~freeze & ~flush;
    end
  endgenerate

  // Next-state: flush beats freeze beats normal transfer.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = FLUSH_VALUE;
      skid_data_d  = FLUSH_VALUE;
    end else if (!freeze) begin
      if (SKID_EN) begin
        if (!main_valid_q) begin
          if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end else if (out_fire) begin
          if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else if (in_fire) begin
            main_data_d  = in_data;
          end else begin
            main_valid_d = 1'b0;
          end
        end else if (in_fire) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end
      end else begin
        if (in_fire) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end else if (out_fire) begin
          main_valid_d = 1'b0;
        end
      end
    end
  end

  // State registers; reset discards every entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= FLUSH_VALUE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= FLUSH_VALUE;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule
